// File: rtl/avalon_pio_pkg.sv
// Shared register map and watchdog state encoding for the watchdog-guarded
// Avalon-MM output port.
package avalon_pio_pkg;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_RSVD     = 3'd1;
    localparam logic [2:0] ADDR_CTRL     = 3'd2;
    localparam logic [2:0] ADDR_STATUS   = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;
    localparam logic [2:0] ADDR_KICK     = 3'd6;
    localparam logic [2:0] ADDR_TIMEOUT  = 3'd7;

    typedef enum logic [1:0] {
        WDG_DISABLED = 2'd0,
        WDG_ARMED    = 2'd1,
        WDG_TRIPPED  = 2'd2
    } wdg_state_e;

endpackage

// File: rtl/pio_wdg_timer.sv
// Watchdog countdown and state machine; raises trip_pulse for one cycle when an
// armed countdown reaches zero without a refresh, then holds tripped until cleared.
module pio_wdg_timer
    import avalon_pio_pkg::*;
#(
    parameter int unsigned          TIMEOUT_W       = 26,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_DEFAULT = TIMEOUT_W'(50_000_000)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 refresh,
    input  logic                 arm,
    input  logic                 disarm,
    input  logic                 clear,
    input  logic                 wdg_en,
    input  logic [TIMEOUT_W-1:0] timeout,
    output logic                 trip_pulse,
    output logic                 tripped
);

    wdg_state_e           state_q, state_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= WDG_DISABLED;
            cnt_q   <= TIMEOUT_DEFAULT;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        trip_pulse = 1'b0;
        case (state_q)
            WDG_DISABLED: begin
                cnt_d = timeout;
                if (arm) begin
                    state_d = WDG_ARMED;
                end
            end
            WDG_ARMED: begin
                // An explicit disarm takes priority over an expiring countdown.
                if (disarm) begin
                    state_d = WDG_DISABLED;
                    cnt_d   = timeout;
                end else if (refresh) begin
                    cnt_d = timeout;
                end else if (cnt_q == '0) begin
                    state_d    = WDG_TRIPPED;
                    trip_pulse = 1'b1;
                end else begin
                    cnt_d = cnt_q - TIMEOUT_W'(1);
                end
            end
            WDG_TRIPPED: begin
                if (clear) begin
                    state_d = wdg_en ? WDG_ARMED : WDG_DISABLED;
                    cnt_d   = timeout;
                end
            end
            default: begin
                state_d = WDG_DISABLED;
                cnt_d   = timeout;
            end
        endcase
    end

    assign tripped = (state_q == WDG_TRIPPED);

endmodule

// File: rtl/avalon_pio_out_wdg.sv
// Avalon-MM output port with atomic set/clear and a watchdog that forces the
// outputs to SAFE_VALUE when software stops refreshing them.
module avalon_pio_out_wdg
    import avalon_pio_pkg::*;
#(
    parameter int unsigned          WIDTH           = 8,
    parameter logic [WIDTH-1:0]     RESET_VALUE     = '0,
    parameter logic [WIDTH-1:0]     SAFE_VALUE      = '0,
    parameter int unsigned          TIMEOUT_W       = 26,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_DEFAULT = TIMEOUT_W'(50_000_000)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic             read_n,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             wdg_tripped
);

    logic [WIDTH-1:0]     data_q, data_d;
    logic                 wdg_en_q, wdg_en_d;
    logic [TIMEOUT_W-1:0] timeout_q, timeout_d;
    logic [31:0]          readdata_q, readdata_d;

    logic             wr, rd, refresh, trip_pulse, tripped;
    logic [WIDTH-1:0] wd;
    logic             unused_wd;

    assign wr        = chipselect & ~write_n;
    assign rd        = chipselect & ~read_n;
    assign wd        = writedata[WIDTH-1:0];
    assign unused_wd = ^writedata;

    assign refresh = wr & ((address == ADDR_DATA)     ||
                           (address == ADDR_OUTSET)   ||
                           (address == ADDR_OUTCLEAR) ||
                           (address == ADDR_KICK));

    pio_wdg_timer #(
        .TIMEOUT_W       (TIMEOUT_W),
        .TIMEOUT_DEFAULT (TIMEOUT_DEFAULT)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .refresh    (refresh),
        .arm        (wr && address == ADDR_CTRL && writedata[0]),
        .disarm     (wr && address == ADDR_CTRL && !writedata[0]),
        .clear      (wr && address == ADDR_STATUS && writedata[0]),
        .wdg_en     (wdg_en_q),
        .timeout    (timeout_q),
        .trip_pulse (trip_pulse),
        .tripped    (tripped)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= RESET_VALUE;
            wdg_en_q   <= 1'b0;
            timeout_q  <= TIMEOUT_DEFAULT;
            readdata_q <= '0;
        end else begin
            data_q     <= data_d;
            wdg_en_q   <= wdg_en_d;
            timeout_q  <= timeout_d;
            readdata_q <= readdata_d;
        end
    end

    always_comb begin
        data_d    = data_q;
        wdg_en_d  = wdg_en_q;
        timeout_d = timeout_q;
        // The trip overrides any output write; once tripped, output writes are dropped.
        if (trip_pulse) begin
            data_d = SAFE_VALUE;
        end else if (wr && !tripped) begin
            case (address)
                ADDR_DATA:     data_d = wd;
                ADDR_OUTSET:   data_d = data_q | wd;
                ADDR_OUTCLEAR: data_d = data_q & ~wd;
                default:       data_d = data_q;
            endcase
        end
        if (wr && address == ADDR_CTRL) begin
            wdg_en_d = writedata[0];
        end
        if (wr && address == ADDR_TIMEOUT) begin
            timeout_d = writedata[TIMEOUT_W-1:0];
        end
    end

    always_comb begin
        readdata_d = readdata_q;
        if (rd) begin
            case (address)
                ADDR_DATA:    readdata_d = 32'(data_q);
                ADDR_CTRL:    readdata_d = {31'd0, wdg_en_q};
                ADDR_STATUS:  readdata_d = {31'd0, tripped};
                ADDR_TIMEOUT: readdata_d = 32'(timeout_q);
                default:      readdata_d = '0;
            endcase
        end
    end

    assign readdata    = readdata_q;
    assign out_port    = data_q;
    assign wdg_tripped = tripped;

endmodule

// File: tb/tb_avalon_pio_out_wdg.sv
// Directed bench for avalon_pio_out_wdg: a vector table for register access
// plus hand-written watchdog timing, precedence and reset sequences.
module tb_avalon_pio_out_wdg;

    localparam logic [7:0] RV   = 8'h5A;
    localparam logic [7:0] SAFE = 8'h3C;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic        read_n = 1'b1;
    logic [31:0] readdata;
    logic [7:0]  out_port;
    logic        wdg_tripped;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    avalon_pio_out_wdg #(
        .WIDTH       (8),
        .RESET_VALUE (RV),
        .SAFE_VALUE  (SAFE)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .address     (address),
        .chipselect  (chipselect),
        .write_n     (write_n),
        .writedata   (writedata),
        .read_n      (read_n),
        .readdata    (readdata),
        .out_port    (out_port),
        .wdg_tripped (wdg_tripped)
    );

    typedef struct {
        bit          is_wr;
        logic [2:0]  addr;
        logic [31:0] wd;
        logic [7:0]  exp_out;
        bit          chk_rd;
        logic [31:0] exp_rd;
        string       name;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Strobes are driven #1 after a rising edge, held for one edge, then released.
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a);
        address = a; chipselect = 1'b1; read_n = 1'b0;
        @(posedge clk); #1;
        chipselect = 1'b0; read_n = 1'b1;
    endtask

    task automatic idle_check(input int n, input logic [7:0] exp_out, input string name);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            check({name, " out"}, 32'(out_port), 32'(exp_out));
            check({name, " trip"}, 32'(wdg_tripped), 32'd0);
        end
    endtask

    task automatic expect_trip_after_11(input logic [7:0] held, input string name);
        idle_check(10, held, name);
        @(posedge clk); #1;
        check({name, " safe"}, 32'(out_port), 32'(SAFE));
        check({name, " tripped"}, 32'(wdg_tripped), 32'd1);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 3'd0, 32'h00,        8'h00, 1'b0, 32'h0,   "wr DATA 00"};
        vecs[1]  = '{1'b1, 3'd4, 32'h81,        8'h81, 1'b0, 32'h0,   "OUTSET 81"};
        vecs[2]  = '{1'b1, 3'd5, 32'h01,        8'h80, 1'b0, 32'h0,   "OUTCLEAR 01"};
        vecs[3]  = '{1'b0, 3'd0, 32'h0,         8'h80, 1'b1, 32'h80,  "rd DATA"};
        vecs[4]  = '{1'b0, 3'd1, 32'h0,         8'h80, 1'b1, 32'h0,   "rd RSVD"};
        vecs[5]  = '{1'b1, 3'd4, 32'h10F,       8'h8F, 1'b0, 32'h0,   "OUTSET hi bits"};
        vecs[6]  = '{1'b0, 3'd4, 32'h0,         8'h8F, 1'b1, 32'h0,   "rd OUTSET"};
        vecs[7]  = '{1'b0, 3'd6, 32'h0,         8'h8F, 1'b1, 32'h0,   "rd KICK"};
        vecs[8]  = '{1'b1, 3'd7, 32'h123,       8'h8F, 1'b0, 32'h0,   "wr TIMEOUT"};
        vecs[9]  = '{1'b0, 3'd7, 32'h0,         8'h8F, 1'b1, 32'h123, "rd TIMEOUT"};
        vecs[10] = '{1'b0, 3'd2, 32'h0,         8'h8F, 1'b1, 32'h0,   "rd CTRL"};
        vecs[11] = '{1'b1, 3'd0, 32'hFFFFFF00,  8'h00, 1'b0, 32'h0,   "DATA hi bits"};

        // Reset state
        #23;
        check("reset out_port", 32'(out_port), 32'(RV));
        check("reset tripped", 32'(wdg_tripped), 32'd0);
        check("reset readdata", readdata, 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        bus_read(3'd7);
        check("reset TIMEOUT", readdata, 32'd50_000_000);
        @(posedge clk); #1;
        check("readdata hold", readdata, 32'd50_000_000);

        // Register access table, watchdog disabled
        foreach (vecs[i]) begin
            if (vecs[i].is_wr) bus_write(vecs[i].addr, vecs[i].wd);
            else               bus_read(vecs[i].addr);
            check({vecs[i].name, " out"}, 32'(out_port), 32'(vecs[i].exp_out));
            if (vecs[i].chk_rd) check({vecs[i].name, " rd"}, readdata, vecs[i].exp_rd);
        end
        idle_check(30, 8'h00, "disabled no trip");

        // Trip timing
        bus_write(3'd7, 32'd10);
        bus_write(3'd2, 32'd1);
        bus_write(3'd0, 32'hFF);
        check("armed data", 32'(out_port), 32'hFF);
        expect_trip_after_11(8'hFF, "trip");

        // While tripped
        bus_write(3'd0, 32'hFF);
        check("tripped write ignored", 32'(out_port), 32'(SAFE));
        bus_write(3'd4, 32'h03);
        check("tripped OUTSET ignored", 32'(out_port), 32'(SAFE));
        bus_read(3'd3);
        check("STATUS tripped", readdata, 32'd1);
        bus_write(3'd3, 32'd1);
        check("STATUS clear", 32'(wdg_tripped), 32'd0);
        bus_read(3'd2);
        check("CTRL armed", readdata, 32'd1);
        bus_write(3'd0, 32'h0F);
        check("post-clear DATA", 32'(out_port), 32'h0F);

        // STATUS clear in the trip cycle is ignored
        idle_check(10, 8'h0F, "pre-trip");
        bus_write(3'd3, 32'd1);
        check("clear in trip cycle safe", 32'(out_port), 32'(SAFE));
        check("clear in trip cycle tripped", 32'(wdg_tripped), 32'd1);

        // Refresh boundary: KICK in the counter==0 cycle
        bus_write(3'd3, 32'd1);
        bus_write(3'd0, 32'hFF);
        idle_check(10, 8'hFF, "pre-kick");
        bus_write(3'd6, 32'h0);
        check("kick beats trip out", 32'(out_port), 32'hFF);
        check("kick beats trip flag", 32'(wdg_tripped), 32'd0);
        expect_trip_after_11(8'hFF, "trip after kick");

        // Disarmed after clear: no trip
        bus_write(3'd2, 32'd0);
        bus_write(3'd3, 32'd1);
        bus_write(3'd0, 32'h55);
        idle_check(25, 8'h55, "disarmed");

        // Asynchronous reset mid-countdown
        bus_write(3'd2, 32'd1);
        bus_write(3'd0, 32'h77);
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("async reset out", 32'(out_port), 32'(RV));
        check("async reset trip", 32'(wdg_tripped), 32'd0);
        #4;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        bus_read(3'd2);
        check("CTRL after reset", readdata, 32'd0);
        bus_read(3'd7);
        check("TIMEOUT after reset", readdata, 32'd50_000_000);
        idle_check(20, RV, "post-reset idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/avalon_pio_out_wdg.md
# avalon_pio_out_wdg

Parametrised Avalon-MM output port for actuator enables and commands, the successor to the single-bit enable PIO in the SOPC system. It holds a WIDTH-bit output register with atomic bit set/clear access. A hardware watchdog forces the outputs to a safe value if software stops refreshing them, so an actuator such as the jack/verin drive never stays enabled after a processor hang.

## Interface
- WIDTH, 8, output port width (1..32)
- RESET_VALUE, 0, value of `out_port` and DATA after reset
- SAFE_VALUE, 0, value forced onto DATA when the watchdog trips
- TIMEOUT_W, 26, width of the watchdog counter and the TIMEOUT register
- TIMEOUT_DEFAULT, 50_000_000, TIMEOUT reset value (1 s at 50 MHz)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  3  word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- read_n  in  1  active-low read strobe
- readdata  out  32  read data, zero-extended, registered
- out_port  out  WIDTH  output register
- wdg_tripped  out  1  watchdog trip flag, for an external LED or interrupt

## Operation
- Register map (word address: name, access):
  - 0: DATA, RW
  - 1: reserved, reads 0
  - 2: CTRL, RW, bit0 = wdg_en
  - 3: STATUS, bit0 = tripped, write 1 to clear
  - 4: OUTSET, W, DATA |= wd
  - 5: OUTCLEAR, W, DATA &= ~wd
  - 6: KICK, W, any value
  - 7: TIMEOUT, RW
- Writes take writedata[WIDTH-1:0]. Higher bits are ignored.
- Reads of OUTSET, OUTCLEAR and KICK return 0.
- Refresh event: an accepted write to DATA, OUTSET, OUTCLEAR or KICK.
- Watchdog states:
  - DISABLED (wdg_en=0): counter is held at TIMEOUT.
  - ARMED: counter decrements by 1 per cycle and reloads to TIMEOUT on a refresh event.
  - TRIPPED: DATA is set to SAFE_VALUE in the trip cycle. Writes to DATA, OUTSET and OUTCLEAR are ignored.
- State transitions:
  - DISABLED→ARMED: on a CTRL write with bit0=1. The counter loads TIMEOUT.
  - ARMED→DISABLED: on a CTRL write with bit0=0.
  - ARMED→TRIPPED: when counter==0 and there is no refresh event in that cycle.
  - TRIPPED→DISABLED or ARMED: on a STATUS write with bit0=1, according to the current wdg_en. The counter reloads.
- Reads and writes never change the watchdog state, except as listed above.

## Timing
- Reset values:
  - DATA and out_port = RESET_VALUE
  - wdg_en = 0
  - tripped and wdg_tripped = 0
  - TIMEOUT = TIMEOUT_DEFAULT
  - counter = TIMEOUT_DEFAULT
  - readdata = 0
- Write to out_port latency: 1 cycle. out_port is a direct register output with no combinational path from the bus.
- Read latency: 1 cycle. readdata is updated on the edge after chipselect & ~read_n, and holds otherwise. There are no wait states.
- Trip latency: TIMEOUT+1 cycles after the last refresh event.
  - out_port shows SAFE_VALUE on the cycle after the trip edge.
  - wdg_tripped rises together with it.
- Precedence rules:
  - A refresh event in the counter==0 cycle beats the trip.
  - A trip beats a DATA write in the same cycle; the write is dropped.
  - A STATUS clear in the trip cycle is ignored; tripped stays 1.
- TIMEOUT=0 while armed: a trip occurs on the first cycle without a refresh event.
- A TIMEOUT write while armed takes effect at the next reload only.
- Asserting reset mid-operation returns every register to its reset value immediately (asynchronous).

## Structure
- Package avalon_pio_pkg holds:
  - the register address constants (ADDR_DATA … ADDR_TIMEOUT)
  - the watchdog state enum {WDG_DISABLED, WDG_ARMED, WDG_TRIPPED}
- Sub-module pio_wdg_timer contains the counter and the state machine.
  - Inputs: refresh, arm/disarm, clear, timeout.
  - Outputs: trip_pulse, tripped.
  - The top level holds the register file and the read mux.

## Test plan
- Reset with WIDTH=8, RESET_VALUE=8'h5A:
  - out_port=8'h5A, wdg_tripped=0.
  - A read of TIMEOUT returns 50_000_000 one cycle after the strobe.
- Bit access, starting from DATA=8'h00:
  - Write OUTSET 0x81, then OUTCLEAR 0x01: out_port goes 8'h81, then 8'h80.
  - A DATA read returns 0x00000080.
- Trip timing:
  - Set TIMEOUT=10, write CTRL=1, write DATA=0xFF.
  - With no further access, out_port=SAFE_VALUE and wdg_tripped=1 exactly 11 cycles after the DATA write edge.
- Refresh boundary:
  - Same setup as the trip test, with a KICK in the counter==0 cycle: no trip.
  - The next trip occurs 11 cycles after the kick.
- While tripped:
  - A DATA write of 0xFF is ignored and out_port stays SAFE_VALUE.
  - Write STATUS=1: tripped clears and the state returns to ARMED.
  - A DATA write of 0x0F then appears on out_port.
- Assert reset_n=0 mid-countdown, asynchronously between clock edges:
  - out_port=RESET_VALUE immediately.
  - CTRL reads 0 after reset release.
